doorlock_ctrl: RTL

Passcode sequencer for the doorlock. It consumes the one-cycle digit strobes (input_v, index) from the keypad button decoder and assembles PW_LEN-digit entries. It compares each entry against a stored password, then drives the door-open window, failure counting/lockout, and password change. It sits between the keypad decoder and the lock actuator/indicator logic.

---
 rtl/doorlock_ctrl_pkg.sv | 28 ++
 rtl/dl_timer.sv | 29 ++
 rtl/doorlock_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/doorlock_ctrl_pkg.sv
// Shared definitions for the doorlock passcode sequencer: key encodings,
// FSM state encoding and small helpers used by the top and the timer sizing.
package doorlock_ctrl_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] IDX_NONE  = 4'hF;
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_SETPW   = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  function automatic logic is_digit(input logic v, input logic [DIGIT_W-1:0] idx);
    return v && (idx != IDX_NONE) && (idx <= MAX_DIGIT);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dl_timer.sv
// Loadable down-counter shared by the entry-timeout, open and lockout phases.
// Loading N makes expire visible so that the consumer acts exactly N edges later.
module dl_timer #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expire = (count == W'(1));

endmodule

// File: rtl/doorlock_ctrl.sv
// Passcode sequencer: collects keypad digits, checks them against the stored
// password, and runs the open window, failure lockout and password change.
module doorlock_ctrl
  import doorlock_ctrl_pkg::*;
#(
  parameter int PW_LEN        = 4,
  parameter int MAX_FAIL      = 3,
  parameter int OPEN_CYCLES   = 500,
  parameter int LOCK_CYCLES   = 1000,
  parameter int ENTRY_TIMEOUT = 2000,
  parameter logic [DIGIT_W*PW_LEN-1:0] DEFAULT_PW = 16'h1234
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         input_v,
  input  logic [3:0]   index,
  input  logic         set_req,
  output logic         door_open,
  output logic         lockout,
  output logic         err_p,
  output logic         pw_set_p,
  output logic [1:0]   fail_cnt,
  output logic [2:0]   digit_cnt
);

  localparam int PW_W  = DIGIT_W * PW_LEN;
  // Wide enough to hold the largest load value itself.
  localparam int TW    = $clog2(max3(OPEN_CYCLES, LOCK_CYCLES, ENTRY_TIMEOUT) + 1);
  localparam logic [2:0] LAST_SLOT = 3'(PW_LEN - 1);
  localparam logic [1:0] FAIL_MAX  = 2'(MAX_FAIL);

  state_t          state, state_d;
  logic [PW_W-1:0] entry_q, entry_d, entry_ins;
  logic [PW_W-1:0] pw_q, pw_d;
  logic [2:0]      digit_cnt_d;
  logic [1:0]      fail_cnt_d;
  logic            err_d, pw_set_d;
  logic            t_load, t_expire;
  logic [TW-1:0]   t_val;
  logic            digit, last;

  assign digit = is_digit(input_v, index);
  assign last  = (digit_cnt == LAST_SLOT);

  // First key entered is the most significant BCD digit, so 16'h1234 is keyed 1,2,3,4.
  always_comb begin
    entry_ins = entry_q;
    for (int i = 0; i < PW_LEN; i++) begin
      if (digit_cnt == 3'(i)) entry_ins[DIGIT_W*(PW_LEN-1-i) +: DIGIT_W] = index;
    end
  end

  // NOTE: every combinational output gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state;
    entry_d     = entry_q;
    pw_d        = pw_q;
    digit_cnt_d = digit_cnt;
    fail_cnt_d  = fail_cnt;
    err_d       = 1'b0;
    pw_set_d    = 1'b0;
    t_load      = 1'b0;
    t_val       = TW'(ENTRY_TIMEOUT);

    case (state)
      S_IDLE: begin
        if (digit) begin
          entry_d     = entry_ins;
          digit_cnt_d = 3'd1;
          t_load      = 1'b1;
          state_d     = (PW_LEN == 1) ? S_CHECK : S_ENTRY;
        end
      end
      S_ENTRY, S_SETPW: begin
        if (digit) begin
          entry_d     = entry_ins;
          digit_cnt_d = digit_cnt + 3'd1;
          t_load      = 1'b1;
          if (last) begin
            if (state == S_ENTRY) begin
              state_d = S_CHECK;
            end else begin
              pw_d        = entry_ins;
              pw_set_d    = 1'b1;
              entry_d     = '0;
              digit_cnt_d = '0;
              state_d     = S_IDLE;
            end
          end
        end else if (t_expire) begin
          entry_d     = '0;
          digit_cnt_d = '0;
          state_d     = S_IDLE;
        end
      end
      S_CHECK: begin
        entry_d     = '0;
        digit_cnt_d = '0;
        if (entry_q == pw_q) begin
          fail_cnt_d = '0;
          t_load     = 1'b1;
          t_val      = TW'(OPEN_CYCLES);
          state_d    = S_OPEN;
        end else begin
          err_d      = 1'b1;
          fail_cnt_d = fail_cnt + 2'd1;
          if (fail_cnt_d == FAIL_MAX) begin
            t_load  = 1'b1;
            t_val   = TW'(LOCK_CYCLES);
            state_d = S_LOCKOUT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_OPEN: begin
        if (set_req) begin
          t_load  = 1'b1;
          state_d = S_SETPW;
        end else if (t_expire) begin
          state_d = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (t_expire) begin
          fail_cnt_d = '0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The stored password is deliberately reset: it is volatile and reverts on every reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      entry_q   <= '0;
      pw_q      <= DEFAULT_PW;
      digit_cnt <= '0;
      fail_cnt  <= '0;
      err_p     <= 1'b0;
      pw_set_p  <= 1'b0;
    end else begin
      state     <= state_d;
      entry_q   <= entry_d;
      pw_q      <= pw_d;
      digit_cnt <= digit_cnt_d;
      fail_cnt  <= fail_cnt_d;
      err_p     <= err_d;
      pw_set_p  <= pw_set_d;
    end
  end

  assign door_open = (state == S_OPEN);
  assign lockout   = (state == S_LOCKOUT);

  dl_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .expire   (t_expire)
  );

endmodule
